// File: rtl/mxint_accumulator.sv
// mxint_accumulator: sums IN_DEPTH MXINT blocks into one exponent-aligned
// MXINT value and broadcasts it on every output lane.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   mdata_in       BLOCK_SIZE input mantissas (signed)
//   edata_in       shared input exponent (signed)
//   data_in_valid  input beat valid
//   data_in_ready  input beat accepted when valid && ready
//   mdata_out      registered sum mantissa, same value on all lanes
//   edata_out      registered sum exponent
//   data_out_valid result valid
//   data_out_ready downstream ready
module mxint_accumulator #(
    parameter int DATA_IN_PRECISION_0  = 16,
    parameter int DATA_IN_PRECISION_1  = 8,
    parameter int BLOCK_SIZE           = 4,
    parameter int IN_DEPTH             = 4,
    parameter int DATA_OUT_PRECISION_0 =
        DATA_IN_PRECISION_0 + $clog2(BLOCK_SIZE * IN_DEPTH),
    parameter int DATA_OUT_PRECISION_1 = DATA_IN_PRECISION_1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_IN_PRECISION_0-1:0]  mdata_in [BLOCK_SIZE],
    input  logic [DATA_IN_PRECISION_1-1:0]  edata_in,
    input  logic                            data_in_valid,
    output logic                            data_in_ready,
    output logic [DATA_OUT_PRECISION_0-1:0] mdata_out [BLOCK_SIZE],
    output logic [DATA_OUT_PRECISION_1-1:0] edata_out,
    output logic                            data_out_valid,
    input  logic                            data_out_ready
);

    localparam int IW = DATA_IN_PRECISION_0;
    localparam int EW = DATA_IN_PRECISION_1;
    localparam int OW = DATA_OUT_PRECISION_0;
    localparam int OE = DATA_OUT_PRECISION_1;
    localparam int BW = IW + $clog2(BLOCK_SIZE);
    localparam int CW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CW-1:0]        cnt_q;
    logic signed [OW-1:0] acc_q;
    logic signed [EW-1:0] exp_q;
    logic signed [OW-1:0] res_q;
    logic [OE-1:0]        res_exp_q;

    logic signed [BW-1:0] bsum;
    logic signed [OW-1:0] bsum_x;
    logic signed [EW:0]   diff;
    logic [EW:0]          diff_neg;
    logic signed [OW-1:0] acc_nxt;
    logic signed [EW-1:0] exp_nxt;
    logic                 accept;
    logic                 last;

    // Arithmetic (floor) right shift; very large shifts saturate to
    // the sign fill instead of relying on shifter wrap behaviour.
    function automatic logic signed [OW-1:0] ashr(
        input logic signed [OW-1:0] v,
        input logic [EW:0]          amt
    );
        if (int'(amt) >= OW)
            ashr = {OW{v[OW-1]}};
        else
            ashr = v >>> amt;
    endfunction

    always_comb begin
        bsum = '0;
        for (int i = 0; i < BLOCK_SIZE; i++)
            bsum = bsum + BW'($signed(mdata_in[i]));
    end

    assign bsum_x = OW'(bsum);

    // One extra bit so the exponent difference cannot wrap.
    assign diff = (EW+1)'($signed(edata_in)) - (EW+1)'(exp_q);
    assign diff_neg = -diff;

    assign accept = data_in_valid && (state_q == ACCUM);
    assign last   = (cnt_q == CW'(IN_DEPTH - 1));

    // Align toward the larger exponent: the older sum is shifted down
    // when the new block is larger, otherwise the new block is.
    always_comb begin
        acc_nxt = acc_q;
        exp_nxt = exp_q;
        if (cnt_q == '0) begin
            acc_nxt = bsum_x;
            exp_nxt = $signed(edata_in);
        end else if (diff > (EW+1)'(0)) begin
            acc_nxt = ashr(acc_q, $unsigned(diff)) + bsum_x;
            exp_nxt = $signed(edata_in);
        end else begin
            acc_nxt = acc_q + ashr(bsum_x, diff_neg);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= ACCUM;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACCUM: if (accept && last) state_d = HOLD;
            HOLD:  if (data_out_ready) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_comb begin
        data_in_ready  = (state_q == ACCUM);
        data_out_valid = (state_q == HOLD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            exp_q     <= '0;
            res_q     <= '0;
            res_exp_q <= '0;
        end else if (accept) begin
            acc_q <= acc_nxt;
            exp_q <= exp_nxt;
            if (last) begin
                cnt_q     <= '0;
                res_q     <= acc_nxt;
                res_exp_q <= OE'(exp_nxt);
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < BLOCK_SIZE; i++)
            mdata_out[i] = res_q;
    end

    assign edata_out = res_exp_q;

endmodule
